oled_hex_stream_disp: RTL

Parametrised successor to the single-shot OLED hex printer. It accepts a byte stream of one position header plus N data bytes and buffers the data. Each byte is then rendered as two hex glyphs (high nibble first) through an external column writer. Versus the previous generation it adds configurable buffer depth, grid size, glyph width and inter-message gap, automatic line wrap, and sticky overflow reporting; it sits between the message source and the OLED column/I2C writer.

---
 rtl/oled_hex_stream_disp.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/oled_hex_stream_disp.sv
// oled_hex_stream_disp
// Receives a header byte {x,y} plus a burst of data bytes, buffers the data,
// then renders every byte as two hex glyphs (high nibble first) by streaming
// glyph columns to an external column writer, one col_start per column.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a header byte
// S_RECV   | accepting data bytes into the buffer
// S_GAP    | holding off until the inter-message gap counter reaches 0
// S_FETCH1 | glyph_addr presented for the current nibble
// S_FETCH2 | glyph ROM data arriving, captured on exit
// S_ISSUE  | col_start pulse with the current column byte
// S_WAIT   | waiting for col_done from the writer
module oled_hex_stream_disp #(
    parameter int BUF_DEPTH = 128,
    parameter int COLS      = 16,
    parameter int ROWS      = 8,
    parameter int GLYPH_W   = 8,
    parameter int DISP_GAP  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        rdy_o,
    input  logic        wen_i,
    input  logic [7:0]  din_i,
    output logic        done_o,
    output logic        overflow_o,
    output logic [3:0]  glyph_addr_o,
    input  logic [63:0] glyph_data_i,
    output logic        col_start_o,
    output logic        col_seq_o,
    output logic [7:0]  col_pos_o,
    output logic [7:0]  col_data_o,
    input  logic        col_done_i
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int GW = (DISP_GAP > 0) ? $clog2(DISP_GAP + 1) : 1;

    localparam logic [3:0]    X_MAX    = 4'(COLS - 1);
    localparam logic [3:0]    Y_MAX    = 4'(ROWS - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(GLYPH_W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_GAP, S_FETCH1, S_FETCH2, S_ISSUE, S_WAIT
    } state_t;

    state_t        state_q;
    logic          rdy_q, done_q, ovf_q;
    logic          col_start_q, col_seq_q;
    logic [7:0]    col_data_q;
    logic [3:0]    glyph_addr_q;
    logic [63:0]   glyph_q;
    logic [3:0]    x_q, y_q;
    logic [CW-1:0] cnt_q, idx_q;
    logic          half_q;
    logic [SW-1:0] sub_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    buf_q [BUF_DEPTH];

    logic [3:0]    x_d, y_d, hdr_x_d, hdr_y_d, nib_d;
    logic [CW-1:0] idx_d;
    logic          half_d, last_glyph_d;
    logic [7:0]    fetch_byte_d;

    // Column byte s of a glyph, column 0 in the top byte.
    function automatic logic [7:0] glyph_byte(input logic [63:0] g, input logic [SW-1:0] s);
        logic [63:0] t;
        t = g << (8 * int'(s));
        return t[63:56];
    endfunction

    // Next cell, next nibble position and header clamping.
    always_comb begin
        x_d = x_q + 4'd1;
        y_d = y_q;
        if (x_q == X_MAX) begin
            x_d = 4'd0;
            y_d = (y_q == Y_MAX) ? 4'd0 : y_q + 4'd1;
        end
        half_d       = ~half_q;
        idx_d        = half_q ? idx_q + CW'(1) : idx_q;
        last_glyph_d = half_q && ((idx_q + CW'(1)) == cnt_q);
        fetch_byte_d = buf_q[idx_d[AW-1:0]];
        nib_d        = half_d ? fetch_byte_d[3:0] : fetch_byte_d[7:4];
        hdr_x_d      = (int'(din_i[7:4]) >= COLS) ? 4'd0 : din_i[7:4];
        hdr_y_d      = (int'(din_i[3:0]) >= ROWS) ? 4'd0 : din_i[3:0];
    end

    // Control FSM with registered outputs, buffer and gap counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b1;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            col_start_q  <= 1'b0;
            col_seq_q    <= 1'b0;
            col_data_q   <= 8'h00;
            glyph_addr_q <= 4'h0;
            glyph_q      <= 64'h0;
            x_q          <= 4'h0;
            y_q          <= 4'h0;
            cnt_q        <= '0;
            idx_q        <= '0;
            half_q       <= 1'b0;
            sub_q        <= '0;
            gap_q        <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= 8'h00;
        end else begin
            done_q      <= 1'b0;
            col_start_q <= 1'b0;
            if (gap_q != '0) gap_q <= gap_q - GW'(1);
            case (state_q)
                S_IDLE: begin
                    if (wen_i) begin
                        x_q     <= hdr_x_d;
                        y_q     <= hdr_y_d;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (wen_i) begin
                        if (cnt_q == CNT_FULL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            buf_q[cnt_q[AW-1:0]] <= din_i;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (cnt_q != '0) begin
                        idx_q   <= '0;
                        half_q  <= 1'b0;
                        sub_q   <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= S_GAP;
                    end else begin
                        // header without data: silently dropped
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        // address goes out one cycle early so ROM data lines up with FETCH2
                        glyph_addr_q <= buf_q[0][7:4];
                        state_q      <= S_FETCH1;
                    end
                end
                S_FETCH1: state_q <= S_FETCH2;
                S_FETCH2: begin
                    glyph_q     <= glyph_data_i;
                    col_data_q  <= glyph_data_i[63:56];
                    col_seq_q   <= 1'b0;
                    col_start_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (col_done_i) begin
                        if (sub_q != SUB_LAST) begin
                            sub_q       <= sub_q + SW'(1);
                            col_data_q  <= glyph_byte(glyph_q, sub_q + SW'(1));
                            col_seq_q   <= 1'b1;
                            col_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end else begin
                            sub_q  <= '0;
                            x_q    <= x_d;
                            y_q    <= y_d;
                            half_q <= half_d;
                            idx_q  <= idx_d;
                            if (last_glyph_d) begin
                                done_q  <= 1'b1;
                                rdy_q   <= 1'b1;
                                gap_q   <= GW'(DISP_GAP);
                                state_q <= S_IDLE;
                            end else begin
                                glyph_addr_q <= nib_d;
                                state_q      <= S_FETCH1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdy_o        = rdy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign glyph_addr_o = glyph_addr_q;
    assign col_start_o  = col_start_q;
    assign col_seq_o    = col_seq_q;
    assign col_pos_o    = {x_q, y_q};
    assign col_data_o   = col_data_q;

endmodule
